// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receive FIFO slice.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage: one synchronous write port, asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  uart_byte_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output uart_byte_t        rdata
);

  uart_byte_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures bytes on the falling edge of rx_int into a first-word-fall-through FIFO.
// Define UART_RX_FIFO_STATS_EN to add the saturating drop_cnt output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_int,
  output logic [7:0]      m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [ADDR_W:0] fifo_level,
  input  logic            clr_ovf,
  output logic            overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [7:0]      drop_cnt
`endif
);

  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic              rx_int_q_reg;
  logic              push_pend_reg;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   level_reg, level_next;
  logic              overflow_reg, overflow_next;
  logic              fall, push, pop, full, drop, wr_en;
  uart_byte_t        mem_rdata;

  assign fall  = rx_int_q_reg & ~rx_int;
  assign push  = push_pend_reg;
  assign full  = (level_reg == LEVEL_FULL);
  assign pop   = m_valid & m_ready;
  // A pop on the same edge frees a slot, so a full FIFO only drops without one.
  assign drop  = push & full & ~pop;
  assign wr_en = push & ~drop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;
    if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)   rd_ptr_next = rd_ptr_reg + PTR_ONE;
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + LEVEL_ONE;
      2'b01:   level_next = level_reg - LEVEL_ONE;
      default: level_next = level_reg;
    endcase
    if (drop)         overflow_next = 1'b1;
    else if (clr_ovf) overflow_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_int_q_reg  <= 1'b0;
      push_pend_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      rx_int_q_reg  <= rx_int;
      push_pend_reg <= fall;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
    end
  end

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en & rst_n),
    .waddr (wr_ptr_reg),
    .wdata (rx_data),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  assign m_valid    = (level_reg != '0);
  // Unreset storage must not leak out while empty.
  assign m_data     = m_valid ? mem_rdata : 8'h00;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0] drop_cnt_reg, drop_cnt_next;

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (clr_ovf)                     drop_cnt_next = drop ? 8'h01 : 8'h00;
    else if (drop && drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_reg <= 8'h00;
    else        drop_cnt_reg <= drop_cnt_next;
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference.
// Drop counter checks are active when UART_RX_FIFO_STATS_EN is defined.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_int;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] fifo_level;
  logic       clr_ovf;
  logic       overflow;
`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0] drop_cnt;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_int     (rx_int),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .clr_ovf    (clr_ovf),
    .overflow   (overflow)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: stored bytes in arrival order, sticky flag, drop count.
  logic [7:0] q[$];
  bit         mdl_ovf;
  int         mdl_cnt;

  // 0: never ready, 1: always ready, 2: ready half the time, 3: ready rarely
  int ready_mode   = 0;
  bit clr_rand     = 0;
  bit clr_now      = 0;
  bit ready_on_push = 0;
  bit clr_on_push  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; push_now says whether the spec's capture timing lands on this edge.
  task automatic tick(input bit push_now);
    bit pop, drop;
    logic [7:0] b;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = ($urandom_range(0, 7) == 0);
    endcase
    if (push_now && ready_on_push) m_ready = 1'b1;
    clr_ovf = clr_now || (clr_rand && $urandom_range(0, 7) == 0) || (push_now && clr_on_push);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      mdl_ovf = 0;
      mdl_cnt = 0;
    end else begin
      pop  = (q.size() != 0) && m_ready;
      drop = push_now && (q.size() == DEPTH) && !pop;
      if (pop) b = q.pop_front();
      if (push_now && !drop) q.push_back(rx_data);
      if (drop) mdl_ovf = 1;
      else if (clr_ovf) mdl_ovf = 0;
      if (clr_ovf) mdl_cnt = drop ? 1 : 0;
      else if (drop && mdl_cnt < 255) mdl_cnt++;
    end
    #1;
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("valid", 32'(m_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head", 32'(m_data), 32'(q[0]));
    chk("overflow", 32'(overflow), 32'(mdl_ovf));
`ifdef UART_RX_FIFO_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(mdl_cnt));
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input int hi, input int lo);
    rx_int = 1'b1;
    repeat (hi) tick(0);
    rx_int  = 1'b0;
    rx_data = b;
    tick(0);
    tick(1);
    repeat (lo - 2) tick(0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rx_int = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clr_ovf = 1'b0;
    mdl_ovf = 0; mdl_cnt = 0;

    // Reset state
    do_reset();
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_valid", 32'(m_valid), 32'h0);
    tick(0);

    // Single byte: visible two edges after rx_int is first sampled low
    rx_int = 1'b1;
    repeat (100) tick(0);
    rx_int = 1'b0; rx_data = 8'hA5;
    tick(0);
    chk("single_not_yet", 32'(m_valid), 32'h0);
    tick(1);
    chk("single_valid", 32'(m_valid), 32'h1);
    chk("single_data", 32'(m_data), 32'hA5);
    chk("single_level", 32'(fifo_level), 32'h1);
    repeat (3) tick(0);

    // Reset on the edge rx_int is first sampled low, with a byte already stored
    rx_int = 1'b1;
    repeat (5) tick(0);
    rx_int = 1'b0; rx_data = 8'h5A; rst_n = 1'b0;
    tick(0);
    rst_n = 1'b1;
    repeat (4) tick(0);
    chk("rst_fall_level", 32'(fifo_level), 32'h0);
    chk("rst_fall_valid", 32'(m_valid), 32'h0);

    // Reset while the push is pending
    rx_int = 1'b1;
    repeat (5) tick(0);
    rx_int = 1'b0; rx_data = 8'h3C;
    tick(0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    repeat (4) tick(0);
    chk("rst_pend_level", 32'(fifo_level), 32'h0);
    chk("rst_pend_valid", 32'(m_valid), 32'h0);

    // Fill, then one frame too many
    ready_mode = 0;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 3, 3);
    send_frame(8'hFF, 3, 3);
    chk("fill_level", 32'(fifo_level), 32'd16);
    chk("fill_overflow", 32'(overflow), 32'h1);
`ifdef UART_RX_FIFO_STATS_EN
    chk("fill_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
    ready_mode = 1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_order", 32'(m_data), 32'(i));
      tick(0);
    end
    chk("fill_empty", 32'(m_valid), 32'h0);
    clr_now = 1; tick(0); clr_now = 0;
    chk("clr_overflow", 32'(overflow), 32'h0);

    // Full FIFO with a pop on the push edge is not an overflow
    ready_mode = 0;
    for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 2, 2);
    ready_on_push = 1;
    send_frame(8'hC3, 2, 2);
    ready_on_push = 0;
    chk("full_pp_overflow", 32'(overflow), 32'h0);
    chk("full_pp_level", 32'(fifo_level), 32'd16);
    ready_mode = 1;
    for (int i = 0; i < 15; i++) begin
      chk("full_pp_order", 32'(m_data), 32'(8'h11 + i));
      tick(0);
    end
    chk("full_pp_last", 32'(m_data), 32'hC3);
    tick(0);

    // Randomized traffic against the reference
    clr_rand = 1;
    for (int i = 0; i < 80; i++) begin
      ready_mode = (i < 40) ? 2 : 3;
      send_frame(8'($urandom), $urandom_range(1, 6), $urandom_range(2, 4));
    end
    clr_rand = 0;
    ready_mode = 1;
    repeat (20) tick(0);
    clr_now = 1; tick(0); clr_now = 0;

    // Long run of drops, then a clear coincident with another drop
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1, 2);
    for (int i = 0; i < 300; i++) send_frame(8'($urandom), 1, 2);
    chk("sat_overflow", 32'(overflow), 32'h1);
`ifdef UART_RX_FIFO_STATS_EN
    chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
`endif
    clr_on_push = 1;
    send_frame(8'h77, 1, 2);
    clr_on_push = 0;
    chk("clr_drop_overflow", 32'(overflow), 32'h1);
`ifdef UART_RX_FIFO_STATS_EN
    chk("clr_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
    clr_now = 1; tick(0); clr_now = 0;
    chk("final_overflow", 32'(overflow), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter ADDR_W, default log2(DEPTH): pointer width; SHALL be derived from DEPTH and never set independently.
REQ-003 Port clk  input  1: single clock, 50 MHz.
REQ-004 Port rst_n  input  1: reset; synchronous, active-low.
REQ-005 Port rx_data  input  8: byte from the upstream UART receiver; valid one clock after rx_int falls.
REQ-006 Port rx_int  input  1: upstream "receiving" flag; high for the duration of a frame.
REQ-007 Port m_data  output  8: head-of-FIFO byte.
REQ-008 Port m_valid  output  1: m_data holds an unread byte.
REQ-009 Port m_ready  input  1: consumer accepts m_data.
REQ-010 Port fifo_level  output  ADDR_W+1: current occupancy, 0..DEPTH.
REQ-011 Port overflow  output  1: sticky flag; a byte was dropped.
REQ-012 Port clr_ovf  input  1: clears overflow (and drop_cnt when present).

Function
REQ-013 Sample rx_int into rx_int_q every clock; fall detected when rx_int_q=1 and rx_int=0.
REQ-014 Fall detection SHALL set a one-cycle push_pend flag; the push SHALL write rx_data on the edge after push_pend is set.
REQ-015 Net effect: the byte is captured on the second edge after rx_int is first sampled low.
REQ-016 A rising edge of rx_int, or rx_int held high, SHALL never cause a push.
REQ-017 FIFO is first-word-fall-through. m_valid=1 whenever fifo_level>0, and m_data = entry at the read pointer.
REQ-018 After a push into an empty FIFO, m_valid SHALL rise on the write edge, i.e. one-cycle latency from push to visibility.
REQ-019 A pop occurs on any edge where m_valid=1 and m_ready=1. m_ready with m_valid=0 SHALL have no effect.
REQ-020 Push and pop on the same edge: both SHALL be performed and fifo_level is unchanged. This includes the full case, which is not an overflow.
REQ-021 Push while full with no pop: the byte is dropped, contents are unchanged, and overflow is set on that edge.
REQ-022 Pointers SHALL wrap modulo DEPTH. fifo_level SHALL equal the write count minus the pop count and never exceed DEPTH.
REQ-023 clr_ovf SHALL clear overflow on the next edge. If clr_ovf and a new overflow occur on the same edge, overflow SHALL remain 1.
REQ-024 m_data SHALL remain stable while m_valid=1 and m_ready=0.

Reset
REQ-025 On any edge with rst_n=0 the block SHALL:
- clear pointers, fifo_level, rx_int_q, push_pend and overflow to 0;
- drive m_valid=0, m_data=8'h00 and drop_cnt=0.
REQ-026 Reset mid-frame or with push_pend set SHALL discard the pending byte. The first push after reset requires a fresh rx_int fall.
REQ-027 Storage array contents need not be reset.

Configuration
REQ-028 Macro UART_RX_FIFO_STATS_EN, when defined, SHALL add output drop_cnt [7:0]:
- increments once per dropped byte;
- saturates at 8'hFF;
- clears on clr_ovf;
- a simultaneous drop and clear SHALL yield 1.
REQ-029 When UART_RX_FIFO_STATS_EN is undefined, drop_cnt and its logic SHALL be absent. All other behaviour is identical.

Structure
REQ-030 Shared package uart_pkg SHALL hold the byte typedef (8-bit) and the UART_FIFO_DEPTH default constant.
REQ-031 Storage SHALL be sub-module uart_fifo_mem: DEPTH x 8, one write port, asynchronous read port. Control, edge detection and flags stay in uart_rx_fifo.

Verification
REQ-032 Single byte:
- stimulus: rx_data=8'hA5, rx_int pulse high for 100 cycles then low, m_ready=0;
- required response: m_valid=1 and m_data=8'hA5 exactly 2 edges after rx_int is first sampled low; fifo_level=1.
REQ-033 Fill:
- stimulus: 16 frames 8'h00..8'h0F with m_ready=0, then a 17th frame 8'hFF;
- required response: fifo_level=16, overflow=1, drop_cnt=1 (macro on); then draining with m_ready=1 yields 8'h00..8'h0F in order, and 8'hFF never appears.
REQ-034 Full plus simultaneous push/pop:
- stimulus: FIFO full, m_ready=1 on the push edge;
- required response: overflow stays 0, fifo_level stays 16, the new byte appears last.
REQ-035 Reset during push_pend:
- stimulus: rst_n=0 for 1 cycle on the edge after rx_int falls;
- required response: fifo_level=0, m_valid=0, no byte written.
REQ-036 Saturation:
- stimulus: 300 overflow drops (macro on);
- required response: drop_cnt=8'hFF;
- then: clr_ovf asserted with a coincident drop gives overflow=1 and drop_cnt=1.
